tweezer_axis_pi_array: RTL and testbench

Multi-axis successor to the single-distance tweezer feedback controller. It runs `NUM_CH` independent PI loops (e.g. X, Y, Z of the bead) on one time-multiplexed multiplier datapath. Each loop has its own setpoint, double-buffered gains and integrator. It sits between the position-detector front end and the trap-steering DAC path.

---
 rtl/tweezer_axis_pi_array_if.sv | 18 +
 rtl/tweezer_axis_pi_array.sv | 217 +++++++++++++++++++++
 tb/tb_tweezer_axis_pi_array.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tweezer_axis_pi_array_if.sv
// Sample-vector stream into the PI array and controller-output stream back out.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates acceptance; the output side is a pulse with no ready.
interface tweezer_axis_pi_array_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*DATA_W-1:0] setpoint;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*OUT_W-1:0]  out_data;
    logic                     out_valid;

    modport master (output in_data, setpoint, in_valid, input in_ready, out_data, out_valid);
    modport slave  (input in_data, setpoint, in_valid, output in_ready, out_data, out_valid);
endinterface

// File: rtl/tweezer_axis_pi_array.sv
// NUM_CH independent PI loops sharing one multiplier; TWEEZER_PI_ANTIWINDUP_EN enables conditional integration.
// Latency: out_valid 2*NUM_CH+1 cycles after accept; one vector per 2*NUM_CH+2 cycles.
// Backpressure: in_ready only in IDLE without a pending commit; output is a one-cycle pulse.
module tweezer_axis_pi_array #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int DATA_FRAC  = 15,
    parameter int COEFF_W    = 10,
    parameter int COEFF_FRAC = 9,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    tweezer_axis_pi_array_if.slave    bus,
    input  logic                      enable,
    input  logic                      freeze,
    input  logic                      pi_reset,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic signed [COEFF_W-1:0] cfg_kp,
    input  logic signed [COEFF_W-1:0] cfg_ki,
    input  logic                      cfg_wr,
    input  logic                      cfg_commit,
    output logic                      commit_pending
);
    localparam int PROD_W = COEFF_W + DATA_W + 1;
    // The sum carries DATA_FRAC+COEFF_FRAC fractional bits; the output carries DATA_FRAC.
    localparam int SHIFT  = (DATA_FRAC + COEFF_FRAC) - DATA_FRAC;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
    state_t state, state_n;
    logic [CH_W-1:0] ch, ch_n;

    logic signed [DATA_W-1:0]  in_q [NUM_CH];
    logic signed [DATA_W-1:0]  sp_q [NUM_CH];
    logic signed [COEFF_W-1:0] kp_sh [NUM_CH], ki_sh [NUM_CH];
    logic signed [COEFF_W-1:0] kp_sh_n [NUM_CH], ki_sh_n [NUM_CH];
    logic signed [COEFF_W-1:0] kp_act [NUM_CH], ki_act [NUM_CH];
    logic signed [ACC_W-1:0]   integ [NUM_CH];
    logic signed [PROD_W-1:0]  p_q, di_q, p_mul, di_mul;
    logic [NUM_CH*OUT_W-1:0]   out_q;

    logic                      accept, do_commit, windup_block;
    logic signed [DATA_W:0]    err;
    logic signed [ACC_W-1:0]   di_ext, integ_sat, integ_upd;
    logic signed [ACC_W:0]     integ_sum, sum_w, shifted;
    logic                      out_hi, out_lo;
    logic [OUT_W-1:0]          res_out;

    assign bus.in_ready  = (state == IDLE) && !commit_pending;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign do_commit     = (state == IDLE) && commit_pending;

    // Shadow next-values; a write in the commit cycle is folded into that commit.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            kp_sh_n[i] = kp_sh[i];
            ki_sh_n[i] = ki_sh[i];
            if (cfg_wr && cfg_ch == CH_W'(i)) begin
                kp_sh_n[i] = cfg_kp;
                ki_sh_n[i] = cfg_ki;
            end
        end
    end

    // Shared multiplier: error and both products for the current channel.
    always_comb begin
        err    = {sp_q[ch][DATA_W-1], sp_q[ch]} - {in_q[ch][DATA_W-1], in_q[ch]};
        p_mul  = kp_act[ch] * err;
        di_mul = ki_act[ch] * err;
    end

`ifdef TWEEZER_PI_ANTIWINDUP_EN
    logic [NUM_CH-1:0] sat_hi, sat_lo;
    assign windup_block = (sat_hi[ch] && !di_q[PROD_W-1] && (di_q != '0))
                       || (sat_lo[ch] && di_q[PROD_W-1]);

    // Remember, per channel, which rail the last output hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_hi <= '0;
            sat_lo <= '0;
        end else if (state == ACC) begin
            sat_hi[ch] <= enable && out_hi;
            sat_lo[ch] <= enable && out_lo;
        end
    end
`else
    assign windup_block = 1'b0;
`endif

    // Integrator update, proportional sum, output scaling and saturation.
    always_comb begin
        di_ext    = ACC_W'(di_q);
        integ_sum = {integ[ch][ACC_W-1], integ[ch]} + {di_ext[ACC_W-1], di_ext};
        integ_sat = integ_sum[ACC_W-1:0];
        if (integ_sum[ACC_W] != integ_sum[ACC_W-1])
            integ_sat = integ_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        integ_upd = integ_sat;
        if (!enable)
            integ_upd = '0;
        else if (freeze || windup_block)
            integ_upd = integ[ch];
        sum_w   = (ACC_W+1)'(p_q) + {integ_upd[ACC_W-1], integ_upd};
        shifted = sum_w >>> SHIFT;
        out_hi  = shifted > OUT_MAX;
        out_lo  = shifted < OUT_MIN;
        res_out = shifted[OUT_W-1:0];
        if (out_hi) res_out = OUT_MAX[OUT_W-1:0];
        if (out_lo) res_out = OUT_MIN[OUT_W-1:0];
        if (!enable) res_out = '0;
    end

    // Sweep sequencer: MUL/ACC per channel, then one DONE cycle.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        case (state)
            IDLE: if (accept) begin
                state_n = MUL;
                ch_n    = '0;
            end
            MUL:  state_n = ACC;
            ACC:  if (ch == CH_W'(NUM_CH-1)) begin
                state_n = DONE;
            end else begin
                state_n = MUL;
                ch_n    = ch + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
        end
    end

    // Sample capture, product pipeline and output slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_q[i] <= '0;
                sp_q[i] <= '0;
            end
            p_q   <= '0;
            di_q  <= '0;
            out_q <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    in_q[i] <= bus.in_data[i*DATA_W +: DATA_W];
                    sp_q[i] <= bus.setpoint[i*DATA_W +: DATA_W];
                end
            end
            if (state == MUL) begin
                p_q  <= p_mul;
                di_q <= di_mul;
            end
            if (state == ACC)
                out_q[ch*OUT_W +: OUT_W] <= res_out;
        end
    end

    // Gain shadows, commit handshake and active gains (only change in IDLE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                kp_sh[i]  <= '0;
                ki_sh[i]  <= '0;
                kp_act[i] <= '0;
                ki_act[i] <= '0;
            end
            commit_pending <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                kp_sh[i] <= kp_sh_n[i];
                ki_sh[i] <= ki_sh_n[i];
                if (do_commit) begin
                    kp_act[i] <= kp_sh_n[i];
                    ki_act[i] <= ki_sh_n[i];
                end
            end
            commit_pending <= cfg_commit || (commit_pending && !do_commit);
        end
    end

    // Integrators: pi_reset wins, then ki-change clear on commit, then ACC update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) integ[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pi_reset)
                    integ[i] <= '0;
                else if (do_commit && ki_sh_n[i] != ki_act[i])
                    integ[i] <= '0;
                else if (state == ACC && ch == CH_W'(i))
                    integ[i] <= integ_upd;
            end
        end
    end
endmodule

// File: tb/tb_tweezer_axis_pi_array.sv
// Directed bench for tweezer_axis_pi_array with an expected-output scoreboard.
// Latency: checks out_valid arrives 7 cycles after accept for NUM_CH=3.
// Backpressure: waits on in_ready (bounded) before each sample.
module tb_tweezer_axis_pi_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, freeze = 1'b0, pi_reset = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [9:0] cfg_kp = '0, cfg_ki = '0;
    logic cfg_wr = 1'b0, cfg_commit = 1'b0;
    logic commit_pending;

    int n_tests = 0;
    int n_fail  = 0;
    logic [47:0] exp_q[$];

    tweezer_axis_pi_array_if #(.NUM_CH(3), .DATA_W(16), .OUT_W(16)) bus ();

    tweezer_axis_pi_array dut (
        .clk(clk), .reset(rst_n), .bus(bus),
        .enable(enable), .freeze(freeze), .pi_reset(pi_reset),
        .cfg_ch(cfg_ch), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki),
        .cfg_wr(cfg_wr), .cfg_commit(cfg_commit),
        .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] v3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cfg_write(input int c, input logic [9:0] kp, input logic [9:0] ki);
        @(negedge clk);
        cfg_ch = 2'(c); cfg_kp = kp; cfg_ki = ki; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic commit_idle();
        int w = 0;
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        check("ready_low_in_commit", bus.in_ready, 1'b0);
        while (commit_pending !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        check("commit_done", commit_pending, 1'b0);
    endtask

    task automatic set_gains(input logic [9:0] kp, input logic [9:0] ki);
        for (int c = 0; c < 3; c++) cfg_write(c, kp, ki);
        commit_idle();
    endtask

    task automatic pulse_pi_reset();
        @(negedge clk); pi_reset = 1'b1;
        @(negedge clk); pi_reset = 1'b0;
    endtask

    // Drive one sample vector, push its expected output, then pop/compare at out_valid.
    task automatic send(input string tag, input logic [47:0] sp, input logic [47:0] din,
                        input logic [47:0] exp_v, input bit commit_mid);
        int w = 0;
        int k;
        logic [47:0] e;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL %s_ready_timeout: in_ready %b required 1", tag, bus.in_ready);
            return;
        end
        bus.setpoint = sp; bus.in_data = din; bus.in_valid = 1'b1;
        exp_q.push_back(exp_v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 1;
        while (bus.out_valid !== 1'b1 && k < 30) begin
            if (commit_mid && k == 2) cfg_commit = 1'b1;
            @(negedge clk);
            k++;
            if (commit_mid && k == 3) begin
                cfg_commit = 1'b0;
                check({tag, "_pending_mid"}, commit_pending, 1'b1);
            end
        end
        check({tag, "_latency"}, 48'(k), 48'd7);
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_scoreboard: queue empty, observed %h", tag, bus.out_data);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.out_data, e);
        end
    endtask

    initial begin
        int quiet;
        bus.in_data = '0; bus.setpoint = '0; bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_data", bus.out_data, 48'h0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_commit_pending", commit_pending, 1'b0);

        // Pure proportional: 0.5 * 0x1000 = 0x0800 on every channel.
        enable = 1'b1;
        set_gains(10'h100, 10'h000);
        send("p_half", v3(16'h1000, 16'h1000, 16'h1000), 48'h0,
             v3(16'h0800, 16'h0800, 16'h0800), 1'b0);

        // Pure integral: 0.125 * 0x1000 accumulates 0x200 per sample; freeze holds.
        set_gains(10'h000, 10'h040);
        send("i_1", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0200, 16'h0200, 16'h0200), 1'b0);
        send("i_2", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0400, 16'h0400, 16'h0400), 1'b0);
        send("i_3", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0600, 16'h0600, 16'h0600), 1'b0);
        freeze = 1'b1;
        send("freeze", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0600, 16'h0600, 16'h0600), 1'b0);
        freeze = 1'b0;

        // Output saturation, both rails, plus a zero-error channel.
        pulse_pi_reset();
        set_gains(10'h1FF, 10'h000);
        send("sat_a", v3(16'h7FFF, 16'h8000, 16'h0000), v3(16'h8000, 16'h7FFF, 16'h0000),
             v3(16'h7FFF, 16'h8000, 16'h0000), 1'b0);
        send("sat_b", v3(16'h8000, 16'h7FFF, 16'h1234), v3(16'h7FFF, 16'h8000, 16'h1234),
             v3(16'h8000, 16'h7FFF, 16'h0000), 1'b0);

        // Commit requested mid-sweep: deferred to IDLE, only channel 1 integrator cleared.
        set_gains(10'h000, 10'h040);
        send("cm_1", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0200, 16'h0200, 16'h0200), 1'b0);
        cfg_write(1, 10'h000, 10'h020);
        send("cm_2", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0400, 16'h0400, 16'h0400), 1'b1);
        send("cm_3", v3(16'h1000, 16'h1000, 16'h1000), 48'h0, v3(16'h0600, 16'h0100, 16'h0600), 1'b0);
        check("cm_pending_clear", commit_pending, 1'b0);

        // Windup: five saturated same-sign samples, then zero error reveals the integrator.
        pulse_pi_reset();
        set_gains(10'h1FF, 10'h008);
        for (int s = 0; s < 5; s++)
            send("wind_sat", v3(16'h7FFF, 16'h7FFF, 16'h7FFF), v3(16'h8000, 16'h8000, 16'h8000),
                 v3(16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
`ifdef TWEEZER_PI_ANTIWINDUP_EN
        send("wind_read", v3(16'h1000, 16'h1000, 16'h1000), v3(16'h1000, 16'h1000, 16'h1000),
             v3(16'h03FF, 16'h03FF, 16'h03FF), 1'b0);
`else
        send("wind_read", v3(16'h1000, 16'h1000, 16'h1000), v3(16'h1000, 16'h1000, 16'h1000),
             v3(16'h13FF, 16'h13FF, 16'h13FF), 1'b0);
`endif

        // Disabled loops output zero and clear integrators.
        enable = 1'b0;
        send("disable", v3(16'h7FFF, 16'h7FFF, 16'h7FFF), v3(16'h8000, 16'h8000, 16'h8000), 48'h0, 1'b0);
        enable = 1'b1;
        send("reenable", v3(16'h1000, 16'h1000, 16'h1000), v3(16'h1000, 16'h1000, 16'h1000), 48'h0, 1'b0);

        // Reset in the middle of a sweep: no out_valid, back to IDLE with cleared outputs.
        @(negedge clk);
        bus.setpoint = v3(16'h1000, 16'h1000, 16'h1000); bus.in_data = '0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) quiet++;
        end
        check("abort_no_valid", 48'(quiet), 48'd0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_out_data", bus.out_data, 48'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
